// File: rtl/ptb_ctrl_pkg.sv
// Shared types and constants for the pretrigger-buffer acquisition controller.
package ptb_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ARMED  = 2'd2,
        ST_RECORD = 2'd3
    } acq_state_e;

    localparam int SETTLE_MIN_CYC = 2;
    localparam int DROP_CNT_WIDTH = 16;

    // Wide enough for pre + post + 1 at their maximum values without wrapping.
    function automatic int rec_len_width(input int pre_w, input int post_w);
        return pre_w + post_w + 1;
    endfunction

endpackage

// File: rtl/ptb_acq_ctrl_if.sv
// PTB-side and waveform-FIFO-side signals of the acquisition controller.
// wr_en is a push-only strobe with no ready: the FIFO takes every word, and
// fifo_afull is consulted only at trigger time to guarantee room for a full record.
interface ptb_acq_ctrl_if #(
    parameter int DATA_W = 22,
    parameter int LTC_W  = 48,
    parameter int PRE_W  = 5
);
    logic              ptb_rdy;
    logic [DATA_W-1:0] ptb_data;
    logic [PRE_W-1:0]  ptb_size_config;
    logic              fifo_afull;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              hdr_valid;
    logic [LTC_W-1:0]  hdr_ltc;

    modport master (
        input  ptb_rdy, ptb_data, fifo_afull,
        output ptb_size_config, wr_en, wr_data, wr_last, hdr_valid, hdr_ltc
    );

    modport slave (
        output ptb_rdy, ptb_data, fifo_afull,
        input  ptb_size_config, wr_en, wr_data, wr_last, hdr_valid, hdr_ltc
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with optional synchronous load and async active-low clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ptb_acq_ctrl.sv
// Sequences one pretrigger buffer: latch config, settle, arm, capture a
// fixed-length record on trigger and push it into the waveform FIFO.
module ptb_acq_ctrl
    import ptb_ctrl_pkg::*;
#(
    parameter int P_PRE_CONF_WIDTH  = 5,
    parameter int P_POST_CONF_WIDTH = 8,
    parameter int P_DATA_WIDTH      = 22,
    parameter int P_LTC_WIDTH       = 48,
    parameter int P_PRE_DEFAULT     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arm,
    input  logic                         disarm,
    input  logic                         cont_mode,
    input  logic [P_PRE_CONF_WIDTH-1:0]  pre_conf_in,
    input  logic [P_POST_CONF_WIDTH-1:0] post_conf_in,
    input  logic                         trig_in,
    input  logic [P_LTC_WIDTH-1:0]       ltc_in,
    ptb_acq_ctrl_if.master               bus,
    output logic                         armed,
    output logic                         busy,
    output logic [DROP_CNT_WIDTH-1:0]    drop_cnt,
    output acq_state_e                   dbg_state
);

    localparam int REC_W    = rec_len_width(P_PRE_CONF_WIDTH, P_POST_CONF_WIDTH);
    localparam int SETTLE_W = $clog2(SETTLE_MIN_CYC + 1);

    acq_state_e                   state_q, state_d;
    logic [P_PRE_CONF_WIDTH-1:0]  pre_q, pre_d;
    logic [P_POST_CONF_WIDTH-1:0] post_q, post_d;
    logic [SETTLE_W-1:0]          settle_q, settle_d;
    logic [REC_W-1:0]             rec_cnt_q, rec_cnt_d;
    logic                         pend_q, pend_d;
    logic                         wr_en_q, wr_en_d;
    logic                         wr_last_q, wr_last_d;
    logic                         hdr_valid_q, hdr_valid_d;
    logic [P_DATA_WIDTH-1:0]      wr_data_q, wr_data_d;
    logic [P_LTC_WIDTH-1:0]       hdr_ltc_q, hdr_ltc_d;
    logic                         armed_q, armed_d;
    logic                         busy_q, busy_d;
    logic                         drop_inc;

    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        post_d      = post_q;
        settle_d    = settle_q;
        rec_cnt_d   = rec_cnt_q;
        pend_d      = pend_q;
        wr_en_d     = 1'b0;
        wr_last_d   = 1'b0;
        hdr_valid_d = 1'b0;
        wr_data_d   = wr_data_q;
        hdr_ltc_d   = hdr_ltc_q;
        drop_inc    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm && !disarm) begin
                    pre_d    = pre_conf_in;
                    post_d   = post_conf_in;
                    settle_d = SETTLE_W'(SETTLE_MIN_CYC);
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // PTB ready drops after a config change, so ignore it until the minimum wait has elapsed.
                if (disarm) begin
                    state_d = ST_IDLE;
                end else if (settle_q != '0) begin
                    settle_d = settle_q - SETTLE_W'(1);
                end else if (bus.ptb_rdy) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (disarm) begin
                    state_d = ST_IDLE;
                end else if (!bus.ptb_rdy) begin
                    settle_d = SETTLE_W'(SETTLE_MIN_CYC);
                    state_d  = ST_SETTLE;
                end else if (trig_in) begin
                    if (bus.fifo_afull) begin
                        drop_inc = 1'b1;
                    end else begin
                        // First word goes out now; the counter holds the L-1 words still to come.
                        state_d     = ST_RECORD;
                        hdr_ltc_d   = ltc_in;
                        rec_cnt_d   = REC_W'(pre_q) + REC_W'(post_q);
                        wr_en_d     = 1'b1;
                        hdr_valid_d = 1'b1;
                        wr_data_d   = bus.ptb_data;
                        wr_last_d   = (pre_q == '0) && (post_q == '0);
                        pend_d      = 1'b0;
                    end
                end
            end
            ST_RECORD: begin
                if (disarm) begin
                    pend_d = 1'b1;
                end
                if (rec_cnt_q != '0) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = bus.ptb_data;
                    wr_last_d = (rec_cnt_q == REC_W'(1));
                    rec_cnt_d = rec_cnt_q - REC_W'(1);
                end else begin
                    pend_d  = 1'b0;
                    state_d = (cont_mode && !pend_q && !disarm) ? ST_ARMED : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        armed_d = (state_d == ST_ARMED);
        busy_d  = (state_d == ST_SETTLE) || (state_d == ST_RECORD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pre_q       <= P_PRE_CONF_WIDTH'(P_PRE_DEFAULT);
            post_q      <= '0;
            settle_q    <= '0;
            rec_cnt_q   <= '0;
            pend_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_last_q   <= 1'b0;
            hdr_valid_q <= 1'b0;
            wr_data_q   <= '0;
            hdr_ltc_q   <= '0;
            armed_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            post_q      <= post_d;
            settle_q    <= settle_d;
            rec_cnt_q   <= rec_cnt_d;
            pend_q      <= pend_d;
            wr_en_q     <= wr_en_d;
            wr_last_q   <= wr_last_d;
            hdr_valid_q <= hdr_valid_d;
            wr_data_q   <= wr_data_d;
            hdr_ltc_q   <= hdr_ltc_d;
            armed_q     <= armed_d;
            busy_q      <= busy_d;
        end
    end

    sat_counter #(
        .WIDTH (DROP_CNT_WIDTH)
    ) u_drop_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (drop_inc),
        .load     (1'b0),
        .load_val ({DROP_CNT_WIDTH{1'b0}}),
        .cnt      (drop_cnt)
    );

    assign bus.ptb_size_config = pre_q;
    assign bus.wr_en           = wr_en_q;
    assign bus.wr_data         = wr_data_q;
    assign bus.wr_last         = wr_last_q;
    assign bus.hdr_valid       = hdr_valid_q;
    assign bus.hdr_ltc         = hdr_ltc_q;
    assign armed               = armed_q;
    assign busy                = busy_q;
    assign dbg_state           = state_q;

endmodule

// File: tb/tb_ptb_acq_ctrl.sv
// Directed bench for ptb_acq_ctrl: record framing, continuous mode, drops,
// deferred disarm, async reset and settle behaviour.
module tb_ptb_acq_ctrl;
    import ptb_ctrl_pkg::*;

    localparam int PRE_W  = 5;
    localparam int POST_W = 8;
    localparam int DW     = 22;
    localparam int LW     = 48;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              arm, disarm, cont_mode, trig_in;
    logic [PRE_W-1:0]  pre_conf_in;
    logic [POST_W-1:0] post_conf_in;
    logic [LW-1:0]     ltc_in;
    logic              armed, busy;
    logic [15:0]       drop_cnt;
    acq_state_e        dbg_state;

    logic              sc_inc, sc_load;
    logic [15:0]       sc_load_val, sc_cnt;

    logic [DW-1:0]     exp_q[$];
    int                total = 0;
    int                bad   = 0;

    ptb_acq_ctrl_if #(.DATA_W(DW), .LTC_W(LW), .PRE_W(PRE_W)) bus ();

    ptb_acq_ctrl #(
        .P_PRE_CONF_WIDTH  (PRE_W),
        .P_POST_CONF_WIDTH (POST_W),
        .P_DATA_WIDTH      (DW),
        .P_LTC_WIDTH       (LW),
        .P_PRE_DEFAULT     (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .disarm       (disarm),
        .cont_mode    (cont_mode),
        .pre_conf_in  (pre_conf_in),
        .post_conf_in (post_conf_in),
        .trig_in      (trig_in),
        .ltc_in       (ltc_in),
        .bus          (bus.master),
        .armed        (armed),
        .busy         (busy),
        .drop_cnt     (drop_cnt),
        .dbg_state    (dbg_state)
    );

    sat_counter #(.WIDTH(16)) u_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (sc_inc),
        .load     (sc_load),
        .load_val (sc_load_val),
        .cnt      (sc_cnt)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        ltc_in       = ltc_in + LW'(1);
        bus.ptb_data = DW'($urandom_range(0, (1 << DW) - 1));
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_armed(input int budget);
        int n = 0;
        while (!armed && n < budget) begin
            tick();
            n++;
        end
        chk("wait_armed", 64'(armed), 64'(1));
    endtask

    task automatic arm_with(input int pre, input int post);
        pre_conf_in  = PRE_W'(pre);
        post_conf_in = POST_W'(post);
        arm          = 1'b1;
        tick();
        arm          = 1'b0;
        chk("arm_latch_pre", 64'(bus.ptb_size_config), 64'(pre));
        chk("arm_state", 64'(dbg_state), 64'(ST_SETTLE));
    endtask

    // Trigger in the current cycle T and check the whole record against the scoreboard.
    task automatic do_record(input int len, input bit hold_trig, input int disarm_at);
        logic [LW-1:0] exp_ltc;
        logic [DW-1:0] exp_w;
        trig_in = 1'b1;
        exp_ltc = ltc_in;
        exp_q.push_back(bus.ptb_data);
        tick();
        if (!hold_trig) trig_in = 1'b0;
        for (int k = 1; k <= len; k++) begin
            chk("rec_wr_en", 64'(bus.wr_en), 64'(1));
            chk("rec_hdr_valid", 64'(bus.hdr_valid), 64'(k == 1));
            chk("rec_wr_last", 64'(bus.wr_last), 64'(k == len));
            exp_w = exp_q.pop_front();
            chk("rec_wr_data", 64'(bus.wr_data), 64'(exp_w));
            if (k == 1) chk("rec_hdr_ltc", 64'(bus.hdr_ltc), 64'(exp_ltc));
            if (k == disarm_at) disarm = 1'b1;
            if (k < len) exp_q.push_back(bus.ptb_data);
            tick();
            disarm = 1'b0;
        end
        chk("rec_end_wr_en", 64'(bus.wr_en), 64'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n_wr;
        int n_idle_busy;

        rst_n          = 1'b0;
        arm            = 1'b0;
        disarm         = 1'b0;
        cont_mode      = 1'b0;
        trig_in        = 1'b0;
        pre_conf_in    = '0;
        post_conf_in   = '0;
        ltc_in         = 48'h1234_0000_0000;
        bus.ptb_rdy    = 1'b0;
        bus.ptb_data   = '0;
        bus.fifo_afull = 1'b0;
        sc_inc         = 1'b0;
        sc_load        = 1'b0;
        sc_load_val    = '0;

        repeat (3) tick();
        chk("rst_size_cfg", 64'(bus.ptb_size_config), 64'(4));
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("rst_wr_en", 64'(bus.wr_en), 64'(0));
        chk("rst_hdr_ltc", 64'(bus.hdr_ltc), 64'(0));
        chk("rst_wr_data", 64'(bus.wr_data), 64'(0));
        chk("rst_armed_busy", 64'({armed, busy}), 64'(0));
        chk("rst_drop", 64'(drop_cnt), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic record: pre=4, post=8, ready rises three cycles after arm, L=13.
        arm_with(4, 8);
        chk("settle_busy", 64'(busy), 64'(1));
        tick();
        tick();
        chk("settle_not_armed", 64'(armed), 64'(0));
        bus.ptb_rdy = 1'b1;
        tick();
        chk("armed_after_rdy", 64'(armed), 64'(1));
        chk("armed_not_busy", 64'(busy), 64'(0));
        do_record(13, 1'b0, 0);
        chk("rec1_idle", 64'(dbg_state), 64'(ST_IDLE));
        chk("rec1_cfg", 64'(bus.ptb_size_config), 64'(4));

        // Continuous mode, trig held through the first record, L=4.
        cont_mode = 1'b1;
        arm_with(1, 2);
        wait_armed(10);
        do_record(4, 1'b1, 0);
        chk("cont_rearmed", 64'(armed), 64'(1));
        trig_in = 1'b0;
        n_wr = 0;
        repeat (15) begin
            tick();
            if (bus.wr_en) n_wr++;
        end
        chk("cont_gap_no_wr", 64'(n_wr), 64'(0));
        chk("cont_no_drop", 64'(drop_cnt), 64'(0));
        do_record(4, 1'b0, 0);
        chk("cont_rearmed2", 64'(armed), 64'(1));
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        chk("cont_disarm_idle", 64'(dbg_state), 64'(ST_IDLE));
        cont_mode = 1'b0;

        // Triggers while the FIFO is almost full are dropped and counted.
        arm_with(1, 2);
        wait_armed(10);
        bus.fifo_afull = 1'b1;
        n_wr = 0;
        repeat (3) begin
            trig_in = 1'b1;
            tick();
            if (bus.wr_en) n_wr++;
            trig_in = 1'b0;
            tick();
            if (bus.wr_en) n_wr++;
        end
        bus.fifo_afull = 1'b0;
        chk("afull_no_wr", 64'(n_wr), 64'(0));
        chk("afull_drop3", 64'(drop_cnt), 64'(3));
        chk("afull_still_armed", 64'(armed), 64'(1));
        disarm = 1'b1;
        tick();
        disarm = 1'b0;

        // Saturation of the drop counter building block.
        sc_load     = 1'b1;
        sc_load_val = 16'hFFFD;
        tick();
        sc_load = 1'b0;
        sc_inc  = 1'b1;
        tick();
        chk("sat_fffe", 64'(sc_cnt), 64'hFFFE);
        tick();
        chk("sat_ffff", 64'(sc_cnt), 64'hFFFF);
        tick();
        chk("sat_hold", 64'(sc_cnt), 64'hFFFF);
        sc_inc = 1'b0;

        // Disarm mid-record is deferred: full 48-word record, then IDLE despite cont_mode.
        cont_mode = 1'b1;
        arm_with(16, 31);
        wait_armed(10);
        do_record(48, 1'b0, 10);
        chk("defer_idle", 64'(dbg_state), 64'(ST_IDLE));
        chk("defer_not_armed", 64'(armed), 64'(0));

        // Disarm and trigger in the same ARMED cycle: disarm wins.
        arm_with(16, 31);
        wait_armed(10);
        trig_in = 1'b1;
        disarm  = 1'b1;
        tick();
        trig_in = 1'b0;
        disarm  = 1'b0;
        chk("dis_trig_idle", 64'(dbg_state), 64'(ST_IDLE));
        chk("dis_trig_no_wr", 64'(bus.wr_en), 64'(0));
        tick();
        chk("dis_trig_no_wr2", 64'(bus.wr_en), 64'(0));
        chk("dis_trig_drop", 64'(drop_cnt), 64'(3));
        cont_mode = 1'b0;

        // Async reset in the first record cycle.
        arm_with(3, 5);
        wait_armed(10);
        trig_in = 1'b1;
        tick();
        trig_in = 1'b0;
        chk("pre_rst_wr_en", 64'(bus.wr_en), 64'(1));
        chk("pre_rst_hdr", 64'(bus.hdr_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_wr_en", 64'(bus.wr_en), 64'(0));
        chk("async_hdr", 64'(bus.hdr_valid), 64'(0));
        chk("async_last", 64'(bus.wr_last), 64'(0));
        chk("async_cfg", 64'(bus.ptb_size_config), 64'(4));
        chk("async_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("async_drop", 64'(drop_cnt), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Ready stays low: controller sits in SETTLE, triggers have no effect.
        bus.ptb_rdy = 1'b0;
        arm_with(31, 0);
        n_wr        = 0;
        n_idle_busy = 0;
        repeat (40) begin
            trig_in = 1'($urandom_range(0, 1));
            tick();
            if (bus.wr_en) n_wr++;
            if (!busy) n_idle_busy++;
        end
        trig_in = 1'b0;
        chk("norr_no_wr", 64'(n_wr), 64'(0));
        chk("norr_busy", 64'(n_idle_busy), 64'(0));
        chk("norr_state", 64'(dbg_state), 64'(ST_SETTLE));
        chk("norr_drop", 64'(drop_cnt), 64'(0));
        bus.ptb_rdy = 1'b1;
        wait_armed(10);
        bus.ptb_rdy = 1'b0;
        tick();
        chk("rdy_drop_state", 64'(dbg_state), 64'(ST_SETTLE));
        chk("rdy_drop_armed", 64'(armed), 64'(0));
        chk("rdy_drop_busy", 64'(busy), 64'(1));
        bus.ptb_rdy = 1'b1;
        wait_armed(10);
        do_record(32, 1'b0, 0);
        chk("last_idle", 64'(dbg_state), 64'(ST_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ptb_acq_ctrl.md
Name: ptb_acq_ctrl

Overview:
Acquisition controller that sequences one pretrigger_buffer channel.
- Latches and applies the pretrigger size configuration, then waits for the buffer to report ready.
- Arms on request and captures a fixed-length record of buffer output words on a trigger.
- Pushes the record into a downstream waveform FIFO, with a timestamp header strobe.
- Sits between the PTB and the waveform FIFO / readout logic.

Parameters:
P_PRE_CONF_WIDTH, 5, width of pretrigger size config
P_POST_CONF_WIDTH, 8, width of post-trigger length config
P_DATA_WIDTH, 22, width of PTB output word
P_LTC_WIDTH, 48, local time counter width
P_PRE_DEFAULT, 4, reset value of applied pretrigger config

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
arm  in  1  single-cycle arm request
disarm  in  1  single-cycle disarm request
cont_mode  in  1  1 = re-arm automatically after each record
pre_conf_in  in  P_PRE_CONF_WIDTH  requested pretrigger samples
post_conf_in  in  P_POST_CONF_WIDTH  requested post-trigger samples
trig_in  in  1  trigger (level; rising edge not required)
ltc_in  in  P_LTC_WIDTH  local time counter
ptb_rdy  in  1  PTB ready
ptb_data  in  P_DATA_WIDTH  PTB output word
ptb_size_config  out  P_PRE_CONF_WIDTH  applied pretrigger config to PTB
fifo_afull  in  1  FIFO cannot accept a maximum-length record
wr_en  out  1  FIFO write strobe
wr_data  out  P_DATA_WIDTH  FIFO write word
wr_last  out  1  final word of record
hdr_valid  out  1  header strobe, coincident with first wr_en
hdr_ltc  out  P_LTC_WIDTH  trigger timestamp
armed  out  1  high in ARMED
busy  out  1  high in SETTLE or RECORD
drop_cnt  out  16  triggers dropped due to fifo_afull, saturating

Behaviour:
- Reset values: state IDLE; ptb_size_config = P_PRE_DEFAULT; post register = 0; wr_en, wr_last, hdr_valid, armed, busy = 0; wr_data, hdr_ltc = 0; drop_cnt = 0.
- States: IDLE, SETTLE, ARMED, RECORD.
- IDLE:
  - arm=1 latches pre_conf_in into ptb_size_config and post_conf_in into the post register.
  - Next state is SETTLE. Both arm and disarm high: disarm wins, stay IDLE.
- SETTLE:
  - 2-cycle minimum wait (PTB ready deasserts after a config change), then wait for ptb_rdy=1, then go to ARMED.
  - disarm returns to IDLE. Config is not re-latched here.
- ARMED:
  - armed=1. trig_in=1 at cycle T with fifo_afull=0: latch ltc_in into hdr_ltc, load the record counter, go to RECORD.
  - trig_in=1 with fifo_afull=1: drop_cnt +1 (saturate at 0xFFFF), stay ARMED.
  - disarm has priority over trig_in in the same cycle and returns to IDLE.
  - ptb_rdy=0: go to SETTLE.
- RECORD:
  - Record length L = pre + post + 1 words, using the latched values.
  - wr_en=1 for L consecutive cycles T+1..T+L. wr_data at cycle k is ptb_data registered from cycle k-1, so the first word is ptb_data at T.
  - hdr_valid=1 only at T+1. wr_last=1 only at T+L.
  - fifo_afull is ignored during RECORD; the afull threshold guarantees room.
  - trig_in is ignored and not counted. disarm is deferred: a pending flag is set and takes effect at record end, so no truncated records are written.
  - Counter width is P_PRE_CONF_WIDTH+P_POST_CONF_WIDTH+1 bits, no wrap.
  - Record end with cont_mode=1 and no pending disarm: go to ARMED at T+L+1.
  - Otherwise go to IDLE. A new arm in IDLE re-latches the config.
- ptb_size_config changes only on the IDLE arm latch.
- Reset asserted mid-RECORD: all outputs return to reset values immediately (async). A partial record is the FIFO owner's concern.

Decomposition:
- Package ptb_ctrl_pkg:
  - state enum (IDLE/SETTLE/ARMED/RECORD)
  - SETTLE_MIN_CYC = 2
  - DROP_CNT_WIDTH = 16
  - record-length width function
- Sub-module sat_counter (parameterised width, increment, saturate, async active-low clear) for drop_cnt.
- Everything else is inline.

Test Plan:
- Reset, arm with pre=4, post=8, ptb_rdy rising 3 cycles later, trig at T -> ptb_size_config=4; armed after ptb_rdy; 13 wr_en cycles; wr_data[0] = ptb_data@T; hdr_valid@T+1; wr_last@T+13; hdr_ltc = ltc@T; IDLE afterwards.
- cont_mode=1, two triggers 20 cycles apart, pre=1, post=2 -> two 4-word records with 1 wr_last each; trig held high through a record produces no extra record and drop_cnt stays 0.
- fifo_afull=1 while ARMED, 3 trigger pulses -> no wr_en, drop_cnt=3. Preload near 0xFFFF -> saturates at 0xFFFF.
- disarm mid-RECORD with pre=16, post=31 -> full 48-word record completes, then IDLE. disarm and trig in the same ARMED cycle -> no record.
- rst_n low mid-RECORD -> wr_en, wr_last, hdr_valid drop without waiting for a clock; ptb_size_config = 4; state IDLE.
- Arm with pre=31 while ptb_rdy stays low for 40 cycles -> busy=1, no record on trig. ptb_rdy drop while ARMED -> SETTLE, armed=0.
